// File: rtl/cga_pkg.sv
// cga_pkg: shared types, slot constants and video address helper for the CGA VRAM arbiter
package cga_pkg;

   typedef enum logic [1:0] {IDLE, PEND, RDWAIT, ACK} cpu_state_t;

   localparam logic [3:0] SLOT_VID0      = 4'd0;
   localparam logic [3:0] SLOT_VID1      = 4'd1;
   localparam logic [3:0] SLOT_CPU_FIRST = 4'd2;

   // Upper 13 bits of a video fetch address; the byte select is appended by the caller
   function automatic logic [12:0] vid_base(input logic gfx, input logic [12:0] ma, input logic ra0);
      return gfx ? {ra0, ma[11:0]} : ma;
   endfunction

endpackage

// File: rtl/cga_slot_timer.sv
// cga_slot_timer: per-character slot counter with video and CPU window decodes
module cga_slot_timer
   import cga_pkg::*;
#(
   parameter int SLOTS_PER_CHAR = 8
) (
   input  logic CLOCK,
   input  logic nRESET,
   input  logic CLKEN,
   output logic vid0,
   output logic vid1,
   output logic cpu_window
);

   localparam logic [3:0] LAST = 4'(SLOTS_PER_CHAR - 1);

   logic [3:0] slot;

   // Saturates in the last slot so the CPU window stays open until the next CLKEN
   always_ff @(posedge CLOCK)
      if (!nRESET) slot <= LAST;
      else slot <= CLKEN ? SLOT_VID0 : (slot == LAST ? slot : slot + 4'd1);

   assign vid0       = slot == SLOT_VID0;
   assign vid1       = slot == SLOT_VID1;
   assign cpu_window = slot >= SLOT_CPU_FIRST;

endmodule

// File: rtl/cga_vram_arbiter.sv
// cga_vram_arbiter: time-slot sharing of the CGA VRAM between CRTC fetches and CPU accesses
module cga_vram_arbiter
   import cga_pkg::*;
#(
   parameter int SLOTS_PER_CHAR = 8
) (
   input  logic        CLOCK,
   input  logic        nRESET,
   input  logic        CLKEN,
   input  logic        gfx_mode,
   input  logic [13:0] MA,
   input  logic [4:0]  RA,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [13:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_ack,
   output logic [7:0]  cpu_rdata,
   output logic [13:0] vram_addr,
   output logic        vram_we,
   output logic [7:0]  vram_wdata,
   input  logic [7:0]  vram_rdata,
   output logic [7:0]  fetch_data0,
   output logic [7:0]  fetch_data1,
   output logic        fetch_valid
);

   logic        vid0, vid1, cpu_window, issue, v0_d, v1_d, req_we;
   logic [12:0] base_live, base_q;
   logic [13:0] addr_q, req_addr;
   logic [7:0]  req_wdata;
   cpu_state_t  state;
   logic        unused_bits;

   assign unused_bits = ^{MA[13], RA[4:1]};

   cga_slot_timer #(.SLOTS_PER_CHAR(SLOTS_PER_CHAR)) u_timer (
      .CLOCK      (CLOCK),
      .nRESET     (nRESET),
      .CLKEN      (CLKEN),
      .vid0       (vid0),
      .vid1       (vid1),
      .cpu_window (cpu_window)
   );

   assign base_live  = vid_base(gfx_mode, MA[12:0], RA[0]);
   assign issue      = state == PEND && cpu_window;
   assign vram_we    = nRESET && issue && req_we;
   assign vram_wdata = req_wdata;
   assign vram_addr  = vid0 ? {base_live, 1'b0} : vid1 ? {base_q, 1'b1} : issue ? req_addr : addr_q;

   // Video pipeline: RAM data lags the address by one cycle
   always_ff @(posedge CLOCK)
      if (!nRESET) begin
         base_q      <= '0;
         v0_d        <= 1'b0;
         v1_d        <= 1'b0;
         fetch_valid <= 1'b0;
         fetch_data0 <= '0;
         fetch_data1 <= '0;
         addr_q      <= '0;
      end else begin
         if (vid0) base_q <= base_live;
         v0_d        <= vid0;
         v1_d        <= vid1;
         fetch_valid <= v1_d;
         if (v0_d) fetch_data0 <= vram_rdata;
         if (v1_d) fetch_data1 <= vram_rdata;
         addr_q      <= vram_addr;
      end

   always_ff @(posedge CLOCK)
      if (!nRESET) begin
         state     <= IDLE;
         cpu_ack   <= 1'b0;
         cpu_rdata <= '0;
         req_we    <= 1'b0;
         req_addr  <= '0;
         req_wdata <= '0;
      end else begin
         cpu_ack <= 1'b0;
         case (state)
            IDLE: if (cpu_req && !cpu_ack) begin
               req_we    <= cpu_we;
               req_addr  <= cpu_addr;
               req_wdata <= cpu_wdata;
               state     <= PEND;
            end
            PEND: if (cpu_window) begin
               state   <= req_we ? ACK : RDWAIT;
               cpu_ack <= req_we;
            end
            RDWAIT: begin
               cpu_rdata <= vram_rdata;
               cpu_ack   <= 1'b1;
               state     <= ACK;
            end
            ACK: state <= IDLE;
            default: state <= IDLE;
         endcase
      end

endmodule
